// File: rtl/apb_downsizer_if.sv
// APB signal bundle shared by the wide upstream and narrow downstream sides of apb_downsizer.
interface apb_downsizer_if #(
   parameter int ADDR_WIDTH = 13,
   parameter int DATA_WIDTH = 32
);
   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_WIDTH-1:0] paddr;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_downsizer.sv
// Splits each wide upstream APB transfer into RATIO narrow downstream beats and reassembles read data.
// Optional macro APB_DS_TIMEOUT_EN adds a downstream access-phase timeout reported as a slave error.
//
// state  | meaning
// IDLE   | waiting for an upstream setup phase
// SETUP  | downstream setup phase of the current beat
// ACCESS | downstream access phase, waiting for M_PREADY
// DONE   | one-cycle upstream completion with assembled data/error
module apb_downsizer #(
   parameter int ADDR_WIDTH     = 13,
   parameter int DATAS_WIDTH    = 32,
   parameter int DATAM_WIDTH    = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic             PCLK,
   input  logic             PRESET,
   apb_downsizer_if.slave   s_apb,
   apb_downsizer_if.master  m_apb
);
   localparam int RATIO      = DATAS_WIDTH / DATAM_WIDTH;
   localparam int BEAT_BYTES = DATAM_WIDTH / 8;
   localparam int BEAT_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'(DATAS_WIDTH / 8 - 1);
   localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(RATIO - 1);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;

   state_e                            state_q, state_d;
   logic [ADDR_WIDTH-1:0]             base_q, base_d;
   logic                              write_q, write_d;
   logic [RATIO-1:0][DATAM_WIDTH-1:0] wdata_q, wdata_d;
   logic [RATIO-1:0][DATAM_WIDTH-1:0] rbuf_q, rbuf_d;
   logic [BEAT_W-1:0]                 beat_q, beat_d;
   logic                              err_q, err_d;
   logic                              timeout;

`ifdef APB_DS_TIMEOUT_EN
   localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [TMR_W-1:0] tmr_q, tmr_d;

   // Down-counter armed in SETUP so it counts only stalled ACCESS cycles of the current beat.
   always_comb begin
      tmr_d = tmr_q;
      if (state_q == SETUP)
         tmr_d = TMR_W'(TIMEOUT_CYCLES - 1);
      else if (state_q == ACCESS && !m_apb.pready && tmr_q != '0)
         tmr_d = tmr_q - 1'b1;
   end

   assign timeout = (state_q == ACCESS) && !m_apb.pready && (tmr_q == '0);

   always_ff @(posedge PCLK) begin
      if (PRESET) tmr_q <= '0;
      else        tmr_q <= tmr_d;
   end
`else
   // Without the timer ACCESS waits forever; the limit only keeps the parameter referenced.
   assign timeout = (TIMEOUT_CYCLES < 0);
`endif

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q <= IDLE;
         base_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         rbuf_q  <= '0;
         beat_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
         rbuf_q  <= rbuf_d;
         beat_q  <= beat_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      write_d = write_q;
      wdata_d = wdata_q;
      rbuf_d  = rbuf_q;
      beat_d  = beat_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (s_apb.psel && !s_apb.penable) begin
               state_d = SETUP;
               base_d  = s_apb.paddr & ~ADDR_MASK;
               write_d = s_apb.pwrite;
               wdata_d = s_apb.pwdata;
               beat_d  = '0;
               rbuf_d  = '0;
               err_d   = 1'b0;
            end
         end
         SETUP: state_d = ACCESS;
         ACCESS: begin
            if (m_apb.pready) begin
               if (!write_q) rbuf_d[beat_q] = m_apb.prdata;
               if (m_apb.pslverr) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else if (beat_q == LAST_BEAT) begin
                  state_d = DONE;
               end else begin
                  beat_d  = beat_q + 1'b1;
                  state_d = SETUP;
               end
            end else if (timeout) begin
               err_d   = 1'b1;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      m_apb.psel    = (state_q == SETUP) || (state_q == ACCESS);
      m_apb.penable = (state_q == ACCESS);
      m_apb.pwrite  = write_q;
      m_apb.paddr   = base_q + ADDR_WIDTH'(beat_q) * ADDR_WIDTH'(BEAT_BYTES);
      m_apb.pwdata  = wdata_q[beat_q];
      s_apb.pready  = (state_q == DONE);
      s_apb.pslverr = (state_q == DONE) && err_q;
      s_apb.prdata  = rbuf_q;
   end
endmodule

// File: tb/tb_apb_downsizer.sv
// Directed bench for apb_downsizer (32->8): writes, reads, waits, slave error, reset abort, stall.
module tb_apb_downsizer;
`ifdef APB_DS_TIMEOUT_EN
   localparam int TMO = 8;
`else
   localparam int TMO = 255;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   apb_downsizer_if #(.ADDR_WIDTH(13), .DATA_WIDTH(32)) s_if ();
   apb_downsizer_if #(.ADDR_WIDTH(13), .DATA_WIDTH(8))  m_if ();

   apb_downsizer #(
      .ADDR_WIDTH(13), .DATAS_WIDTH(32), .DATAM_WIDTH(8), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .PCLK(clk), .PRESET(rst), .s_apb(s_if), .m_apb(m_if)
   );

   int checks = 0;
   int errors = 0;

   logic [12:0] b_addr  [8];
   logic [7:0]  b_wdata [8];
   logic        b_wr    [8];
   logic [7:0]  rd_bytes[4];
   int          nset;
   logic        hold_ok;

   // Acts as upstream master and downstream slave; latency is returned in upstream cycles (-1 on hang).
   task automatic run_xfer(input logic wr, input logic [12:0] addr, input logic [31:0] wdata,
                           input int wait_beat, input int wait_n, input int err_beat, input int budget,
                           output int lat, output logic [31:0] rdata, output logic slverr);
      int  n;
      int  ndone;
      int  wleft;
      bit  done;
      s_if.psel = 1'b1; s_if.penable = 1'b0; s_if.pwrite = wr;
      s_if.paddr = addr; s_if.pwdata = wdata;
      @(posedge clk); #1;
      s_if.penable = 1'b1;
      nset = 0; ndone = 0; wleft = 0; hold_ok = 1'b1; done = 0; n = 0;
      rdata = 'x; slverr = 1'bx; lat = -1;
      while (!done && n < budget) begin
         m_if.pready = 1'b0; m_if.pslverr = 1'b0; m_if.prdata = 8'h00;
         if (m_if.psel && !m_if.penable && nset < 8) begin
            b_addr[nset] = m_if.paddr; b_wdata[nset] = m_if.pwdata; b_wr[nset] = m_if.pwrite;
            wleft = (nset == wait_beat) ? wait_n : 0;
            nset++;
         end else if (m_if.psel && m_if.penable && nset > 0) begin
            if (m_if.paddr !== b_addr[nset-1] || m_if.pwdata !== b_wdata[nset-1]) hold_ok = 1'b0;
            if (wleft > 0) begin
               wleft--;
            end else begin
               m_if.pready  = 1'b1;
               m_if.prdata  = rd_bytes[ndone % 4];
               m_if.pslverr = (ndone == err_beat);
               ndone++;
            end
         end
         if (s_if.pready) begin
            rdata = s_if.prdata; slverr = s_if.pslverr; lat = n + 1; done = 1;
         end else begin
            @(posedge clk); #1;
            n++;
         end
      end
      @(posedge clk); #1;
      s_if.psel = 1'b0; s_if.penable = 1'b0;
      m_if.pready = 1'b0; m_if.pslverr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({m_if.psel, m_if.penable, m_if.pwrite, s_if.pready, s_if.pslverr} !== 5'b0) begin
         errors++; $display("FAIL reset_ctrl got %b want 00000",
                            {m_if.psel, m_if.penable, m_if.pwrite, s_if.pready, s_if.pslverr});
      end
      checks++;
      if (m_if.paddr !== 13'h0 || m_if.pwdata !== 8'h0 || s_if.prdata !== 32'h0) begin
         errors++; $display("FAIL reset_data got addr=%h wdata=%h rdata=%h want 0",
                            m_if.paddr, m_if.pwdata, s_if.prdata);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_write();
      int lat; logic [31:0] rd; logic se;
      logic [7:0] exp_d[4];
      exp_d[0] = 8'hD4; exp_d[1] = 8'hC3; exp_d[2] = 8'hB2; exp_d[3] = 8'hA1;
      run_xfer(1'b1, 13'h104, 32'hA1B2C3D4, 99, 0, 99, 100, lat, rd, se);
      checks++;
      if (nset !== 4) begin errors++; $display("FAIL wr_beats got %0d want 4", nset); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (b_addr[i] !== 13'h104 + 13'(i) || b_wdata[i] !== exp_d[i] || b_wr[i] !== 1'b1) begin
            errors++; $display("FAIL wr_beat%0d got addr=%h data=%h wr=%b want addr=%h data=%h wr=1",
                               i, b_addr[i], b_wdata[i], b_wr[i], 13'h104 + 13'(i), exp_d[i]);
         end
      end
      checks++;
      if (lat !== 9 || se !== 1'b0 || rd !== 32'h0) begin
         errors++; $display("FAIL wr_done got lat=%0d err=%b rdata=%h want lat=9 err=0 rdata=0", lat, se, rd);
      end
   endtask

   task automatic test_read();
      int lat; logic [31:0] rd; logic se;
      rd_bytes[0] = 8'h11; rd_bytes[1] = 8'h22; rd_bytes[2] = 8'h33; rd_bytes[3] = 8'h44;
      run_xfer(1'b0, 13'h107, 32'hFFFF_FFFF, 99, 0, 99, 100, lat, rd, se);
      checks++;
      if (b_addr[0] !== 13'h104 || b_addr[3] !== 13'h107 || b_wr[0] !== 1'b0) begin
         errors++; $display("FAIL rd_addr got first=%h last=%h wr=%b want 104 107 0", b_addr[0], b_addr[3], b_wr[0]);
      end
      checks++;
      if (rd !== 32'h44332211 || se !== 1'b0 || lat !== 9) begin
         errors++; $display("FAIL rd_data got %h err=%b lat=%0d want 44332211 err=0 lat=9", rd, se, lat);
      end
   endtask

   task automatic test_wait_states();
      int lat; logic [31:0] rd; logic se;
      rd_bytes[0] = 8'h5A; rd_bytes[1] = 8'h6B; rd_bytes[2] = 8'h7C; rd_bytes[3] = 8'h8D;
      run_xfer(1'b0, 13'h104, 32'h0, 2, 3, 99, 100, lat, rd, se);
      checks++;
      if (lat !== 12) begin errors++; $display("FAIL wait_lat got %0d want 12", lat); end
      checks++;
      if (b_addr[2] !== 13'h106 || hold_ok !== 1'b1) begin
         errors++; $display("FAIL wait_hold got addr=%h held=%b want 106 1", b_addr[2], hold_ok);
      end
      checks++;
      if (rd !== 32'h8D7C6B5A) begin errors++; $display("FAIL wait_data got %h want 8d7c6b5a", rd); end
   endtask

   task automatic test_slverr();
      int lat; logic [31:0] rd; logic se;
      rd_bytes[0] = 8'h11; rd_bytes[1] = 8'h22; rd_bytes[2] = 8'h33; rd_bytes[3] = 8'h44;
      run_xfer(1'b0, 13'h200, 32'h0, 99, 0, 1, 100, lat, rd, se);
      checks++;
      if (nset !== 2) begin errors++; $display("FAIL err_beats got %0d want 2", nset); end
      checks++;
      if (se !== 1'b1 || rd !== 32'h00002211 || lat !== 5) begin
         errors++; $display("FAIL err_done got err=%b rdata=%h lat=%0d want 1 00002211 5", se, rd, lat);
      end
   endtask

   task automatic test_back_to_back();
      int lat1, lat2; logic [31:0] rd1, rd2; logic se1, se2;
      rd_bytes[0] = 8'hEF; rd_bytes[1] = 8'hBE; rd_bytes[2] = 8'hAD; rd_bytes[3] = 8'hDE;
      run_xfer(1'b1, 13'h1FFE, 32'h01234567, 99, 0, 99, 100, lat1, rd1, se1);
      checks++;
      if (b_addr[0] !== 13'h1FFC || b_addr[3] !== 13'h1FFF || b_wdata[1] !== 8'h45) begin
         errors++; $display("FAIL b2b_wr got a0=%h a3=%h d1=%h want 1ffc 1fff 45", b_addr[0], b_addr[3], b_wdata[1]);
      end
      run_xfer(1'b0, 13'h010, 32'h0, 99, 0, 99, 100, lat2, rd2, se2);
      checks++;
      if (lat1 !== 9 || lat2 !== 9 || rd2 !== 32'hDEADBEEF || se2 !== 1'b0) begin
         errors++; $display("FAIL b2b_rd got lat=%0d/%0d rdata=%h err=%b want 9/9 deadbeef 0", lat1, lat2, rd2, se2);
      end
   endtask

   task automatic test_reset_mid();
      int lat; logic [31:0] rd; logic se;
      bit hit = 0;
      int ns = 0;
      s_if.psel = 1'b1; s_if.penable = 1'b0; s_if.pwrite = 1'b0; s_if.paddr = 13'h300;
      @(posedge clk); #1;
      s_if.penable = 1'b1;
      for (int i = 0; i < 20 && !hit; i++) begin
         m_if.pready = 1'b0;
         if (m_if.psel && !m_if.penable) ns++;
         if (m_if.psel && m_if.penable) begin
            if (ns == 3) hit = 1;
            else m_if.pready = 1'b1;
         end
         if (!hit) begin @(posedge clk); #1; end
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; s_if.psel = 1'b0; s_if.penable = 1'b0;
      checks++;
      if (!hit || m_if.psel !== 1'b0 || m_if.penable !== 1'b0 || s_if.pready !== 1'b0 || m_if.paddr !== 13'h0) begin
         errors++; $display("FAIL mid_reset got reached=%0d psel=%b pen=%b pready=%b addr=%h want 1 0 0 0 0",
                            hit, m_if.psel, m_if.penable, s_if.pready, m_if.paddr);
      end
      @(posedge clk); #1;
      run_xfer(1'b1, 13'h044, 32'hCAFEF00D, 99, 0, 99, 100, lat, rd, se);
      checks++;
      if (lat !== 9 || se !== 1'b0 || b_wdata[0] !== 8'h0D || b_wdata[3] !== 8'hCA || b_addr[0] !== 13'h044) begin
         errors++; $display("FAIL post_reset got lat=%0d err=%b d0=%h d3=%h a0=%h want 9 0 0d ca 044",
                            lat, se, b_wdata[0], b_wdata[3], b_addr[0]);
      end
   endtask

   task automatic test_stall();
      int lat; logic [31:0] rd; logic se;
      rd_bytes[0] = 8'h99; rd_bytes[1] = 8'h88; rd_bytes[2] = 8'h77; rd_bytes[3] = 8'h66;
      run_xfer(1'b0, 13'h080, 32'h0, 0, 1000, 99, 2000, lat, rd, se);
`ifdef APB_DS_TIMEOUT_EN
      checks++;
      if (lat !== 10 || se !== 1'b1 || rd !== 32'h0 || nset !== 1) begin
         errors++; $display("FAIL timeout got lat=%0d err=%b rdata=%h beats=%0d want 10 1 0 1", lat, se, rd, nset);
      end
`else
      checks++;
      if (lat !== 1009 || se !== 1'b0 || hold_ok !== 1'b1 || rd !== 32'h66778899) begin
         errors++; $display("FAIL stall got lat=%0d err=%b held=%b rdata=%h want 1009 0 1 66778899",
                            lat, se, hold_ok, rd);
      end
`endif
   endtask

   initial begin
      s_if.psel = 1'b0; s_if.penable = 1'b0; s_if.pwrite = 1'b0;
      s_if.paddr = '0; s_if.pwdata = '0;
      m_if.pready = 1'b0; m_if.pslverr = 1'b0; m_if.prdata = '0;
      for (int i = 0; i < 4; i++) rd_bytes[i] = 8'h00;
      test_reset();
      test_write();
      test_read();
      test_wait_states();
      test_slverr();
      test_back_to_back();
      test_reset_mid();
      test_stall();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/apb_downsizer.md
# apb_downsizer

Parametrised APB width-downsizing bridge between a wide upstream APB master and a narrow downstream APB segment. Each upstream transfer is split into RATIO = DATAS_WIDTH/DATAM_WIDTH sequential downstream transfers at consecutive byte addresses. Read data is reassembled, and slave errors abort the remaining beats. An optional compile-time timeout reports a hung downstream slave as an error.

## Interface
- ADDR_WIDTH, 13, address width on both sides.
- DATAS_WIDTH, 32, upstream (slave-port) data width; power of two, ≥ DATAM_WIDTH.
- DATAM_WIDTH, 8, downstream (master-port) data width; power of two, ≥ 8.
- TIMEOUT_CYCLES, 255, downstream access-phase limit in cycles (used only with APB_DS_TIMEOUT_EN); ≥ 1.
- Derived: RATIO = DATAS_WIDTH/DATAM_WIDTH; BEAT_BYTES = DATAM_WIDTH/8.
- PCLK  in  1  clock, all logic on rising edge.
- PRESET  in  1  reset, synchronous, active-high.
- S_PSEL, S_PENABLE, S_PWRITE  in  1 each  upstream APB controls.
- S_PADDR  in  ADDR_WIDTH  upstream address.
- S_PWDATA  in  DATAS_WIDTH  upstream write data.
- S_PRDATA  out  DATAS_WIDTH  assembled read data.
- S_PREADY, S_PSLVERR  out  1 each  upstream completion and error.
- M_PSEL, M_PENABLE, M_PWRITE  out  1 each  downstream APB controls.
- M_PADDR  out  ADDR_WIDTH  downstream address.
- M_PWDATA  out  DATAM_WIDTH  downstream write data.
- M_PRDATA  in  DATAM_WIDTH  downstream read data.
- M_PREADY, M_PSLVERR  in  1 each  downstream completion and error.

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE. All outputs are driven from registers or the registered state. There are no combinational input-to-output paths.
- IDLE → SETUP on S_PSEL=1 and S_PENABLE=0. At that edge:
  - latch base = S_PADDR with its low log2(DATAS_WIDTH/8) bits forced to 0;
  - latch S_PWRITE and S_PWDATA;
  - set beat = 0;
  - clear the read buffer to 0.
- SETUP: M_PSEL=1, M_PENABLE=0, M_PADDR = base + beat*BEAT_BYTES, M_PWRITE = latched value, M_PWDATA = S_PWDATA slice [beat] (beat 0 is the LSB slice). Next state is always ACCESS.
- ACCESS: M_PSEL=1, M_PENABLE=1, with address and data held. The state holds while M_PREADY=0. On M_PREADY=1:
  - on a read, capture M_PRDATA into read-buffer slice [beat];
  - if M_PSLVERR=1, go to DONE with err=1 and issue no further beats;
  - else if beat = RATIO-1, go to DONE;
  - else increment beat and go to SETUP.
- DONE: S_PREADY=1 for exactly one cycle, with S_PSLVERR = err and S_PRDATA = read buffer. M_PSEL and M_PENABLE are 0. Next state is IDLE. err clears on the next accept.
- Writes return S_PRDATA = 0.
- Upstream S_PSEL or S_PENABLE changes while the bridge is busy are ignored. Upstream compliance is assumed per the APB protocol.
- RATIO = 1 is legal and behaves as a single-beat registered pass-through.

## Timing
- Reset values: S_PREADY=0, S_PSLVERR=0, S_PRDATA=0, M_PSEL=0, M_PENABLE=0, M_PWRITE=0, M_PADDR=0, M_PWDATA=0. State is IDLE.
- Reset mid-transfer: state is IDLE and all outputs take their reset values in the cycle after PRESET is sampled high. The downstream transfer is abandoned without completion.
- Latency: upstream setup sampled in cycle T → S_PREADY=1 in cycle T + 1 + 2*RATIO + W, where W is the total number of downstream wait cycles.
- Each downstream beat takes 2 + wait cycles. Consecutive beats are separated by a SETUP cycle, so M_PSEL stays high and M_PENABLE drops for one cycle.
- Back-to-back transfers: a new upstream setup is accepted in the cycle immediately after DONE.
- Address arithmetic is modulo 2^ADDR_WIDTH; beats that cross the top of the address space wrap to 0.

## Configuration
- APB_DS_TIMEOUT_EN defined:
  - a counter clears on entry to ACCESS and increments on each ACCESS cycle with M_PREADY=0;
  - when it reaches TIMEOUT_CYCLES, the FSM goes to DONE with err=1 and M_PSEL/M_PENABLE drop;
  - remaining read slices stay 0.
- APB_DS_TIMEOUT_EN undefined: no counter exists, ACCESS waits indefinitely, and TIMEOUT_CYCLES is ignored.

## Test plan
- Write, 32→8, S_PADDR=0x104, S_PWDATA=0xA1B2C3D4, M_PREADY=1:
  - downstream beats at 0x104/0x105/0x106/0x107 carry 0xD4/0xC3/0xB2/0xA1;
  - S_PREADY=1 at T+9, S_PSLVERR=0, S_PRDATA=0.
- Read from S_PADDR=0x107 with M_PRDATA=0x11,0x22,0x33,0x44 → M_PADDR starts at 0x104, S_PRDATA=0x44332211.
- Read with M_PREADY low for 3 cycles on beat 2 → S_PREADY at T+12, M_PADDR=0x106 held through the waits.
- M_PSLVERR=1 on beat 1 of a read (data 0x11, 0x22) → no beats 2 or 3 issued, S_PSLVERR=1, S_PRDATA=0x00002211, S_PREADY at T+5.
- PRESET pulsed during beat 2 ACCESS → next cycle M_PSEL=0, M_PENABLE=0, S_PREADY=0. A following transfer completes normally.
- With APB_DS_TIMEOUT_EN and TIMEOUT_CYCLES=8, M_PREADY stuck at 0 on beat 0 → M_PSEL drops after 8 ACCESS cycles, then S_PREADY=1 with S_PSLVERR=1. Without the macro, the bridge is still in ACCESS after 1000 cycles.
